spy_round_ctrl: RTL and testbench
=================================

Name: spy_round_ctrl

Overview:
Round sequencer for the two-player Morse game. Enables player 1 to enter a secret code, then enables player 2 to reproduce it against a countdown. Judges the attempt from the player-2 match flag, keeps score and counts rounds. Sits above the player-1 entry block and the player-2 decoder/comparator; drives their enables and clears.

Parameters:
TIME_LIMIT, 30, player-2 countdown length in tick periods (1..2^TIMER_W-1)
NUM_ROUNDS, 5, rounds per game (1..2^ROUND_W-1)
TIMER_W, 6, countdown width
ROUND_W, 4, round counter and score width

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  level; begins a game from IDLE or DONE
tick  in  1  one-cycle timebase enable (e.g. 1 Hz strobe)
p1_finish  in  1  player 1 has finished entering the code
p2_finish  in  1  player 2 has finished entering the attempt
p2_match  in  1  player-2 value equals player-1 value (combinational from comparator)
p1_en  out  1  player-1 entry enabled
p2_en  out  1  player-2 entry enabled
p1_clear  out  1  one-cycle clear of player-1 value
p2_clear  out  1  one-cycle clear of player-2 value
time_left  out  TIMER_W  remaining countdown
round  out  ROUND_W  current round, 1-based; 0 when idle
score  out  ROUND_W  rounds won by player 2
win  out  1  one-cycle pulse on a judged win
lose  out  1  one-cycle pulse on a judged loss or timeout
game_over  out  1  high in DONE

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- All outputs are registered.
- Reset values: state IDLE; all outputs 0; time_left 0.
- States: IDLE, P1_ENTRY, P2_ENTRY, CHECK, RESULT, DONE.
- IDLE: start=1 -> P1_ENTRY; round<=1, score<=0; p1_clear and p2_clear pulse in the same transition cycle.
- P1_ENTRY: p1_en=1. p1_finish=1 -> P2_ENTRY, with time_left<=TIME_LIMIT and a p2_clear pulse.
- P2_ENTRY: p2_en=1.
  - tick=1 and time_left>0 -> time_left decrements.
  - p2_finish=1 -> CHECK; the timer freezes.
  - tick=1 with time_left==1 and no finish -> time_left<=0, then RESULT with a lose pulse.
  - Simultaneous p2_finish and final tick: finish wins and the timer is not decremented.
- CHECK: exactly one cycle; p2_en=0; p2_match is sampled.
  - p2_match=1 -> win pulse, score+1 (saturating at all-ones).
  - p2_match=0 -> lose pulse.
  - Then RESULT.
- RESULT: exactly one cycle.
  - round==NUM_ROUNDS -> DONE.
  - Otherwise round+1, p1_clear and p2_clear pulse, -> P1_ENTRY.
- DONE: game_over=1; score and round hold. start=1 -> behaves as IDLE start.
- win and lose are never high together; each is high for exactly one cycle per round.
- Any tick outside P2_ENTRY is ignored; p1_finish outside P1_ENTRY is ignored; p2_finish outside P2_ENTRY is ignored.
- Reset mid-round: returns to IDLE next edge. No win/lose pulse is emitted.

Optional Feature:
SPY_STRIKES_EN
- Defined: a 2-bit strike counter increments on each lose pulse and clears at game start. The third strike forces DONE from RESULT regardless of round. An extra output, strikes [1:0], is exported.
- Undefined: no strike counter or port; the game always runs NUM_ROUNDS rounds.

Decomposition:
- Shared package spy_pkg holds:
  - the state enum and its encoding (3 bits);
  - default TIME_LIMIT and NUM_ROUNDS constants;
  - the strike limit constant (3).
- One natural sub-module: spy_countdown, holding the load/decrement/freeze timer with a zero flag. The FSM, score and round logic stay in the top.

Test Plan:
- Reset then start, p1_finish, p2_finish with p2_match=1 and NUM_ROUNDS=1 -> one win pulse in CHECK+1; score=1; game_over=1; round=1.
- TIME_LIMIT=3, three ticks in P2_ENTRY with no finish -> time_left 3,2,1,0; lose pulse; score unchanged.
- p2_finish and tick on the same cycle with time_left=1 -> CHECK taken, time_left stays 1, judged by p2_match.
- NUM_ROUNDS=5, alternate match 1/0 -> score=3, round=5, game_over set. p1_clear/p2_clear pulse at each round start.
- Assert reset during P2_ENTRY with time_left=10 -> next cycle all outputs 0, state IDLE, no win/lose pulse.
- SPY_STRIKES_EN, NUM_ROUNDS=5, three mismatches -> strikes=3 (saturated display 2'b11), game_over after round 3.

Source files
------------

// File: rtl/spy_pkg.sv
// Shared types and constants for the spy round controller.
// The optional strike feature is enabled with the SPY_STRIKES_EN macro.
package spy_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_P1     = 3'd1,
    S_P2     = 3'd2,
    S_CHECK  = 3'd3,
    S_RESULT = 3'd4,
    S_DONE   = 3'd5
  } spy_state_e;

  localparam int SPY_TIME_LIMIT   = 30;
  localparam int SPY_NUM_ROUNDS   = 5;
  localparam int SPY_STRIKE_LIMIT = 3;

endpackage

// File: rtl/spy_countdown.sv
// Player-2 countdown: load, decrement on enable, otherwise hold (freeze).
// zero flags an exhausted count so the controller can treat it as a timeout.
module spy_countdown #(
  parameter int W = 6
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         zero
);

  // Counter register; load has priority, decrement never wraps below zero.
  always_ff @(posedge clock) begin
    if (reset)                   count <= '0;
    else if (load)               count <= load_val;
    else if (dec && count != '0) count <= count - 1'b1;
  end

  assign zero = (count == '0);

endmodule

// File: rtl/spy_round_ctrl.sv
// Round sequencer for the two-player Morse game.
// Optional feature: define SPY_STRIKES_EN to add a strike counter that ends
// the game after the third loss and exports strikes[1:0].
module spy_round_ctrl
  import spy_pkg::*;
#(
  parameter int TIME_LIMIT = SPY_TIME_LIMIT,
  parameter int NUM_ROUNDS = SPY_NUM_ROUNDS,
  parameter int TIMER_W    = 6,
  parameter int ROUND_W    = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               tick,
  input  logic               p1_finish,
  input  logic               p2_finish,
  input  logic               p2_match,
  output logic               p1_en,
  output logic               p2_en,
  output logic               p1_clear,
  output logic               p2_clear,
  output logic [TIMER_W-1:0] time_left,
  output logic [ROUND_W-1:0] round,
  output logic [ROUND_W-1:0] score,
  output logic               win,
  output logic               lose,
`ifdef SPY_STRIKES_EN
  output logic               game_over,
  output logic [1:0]         strikes
`else
  output logic               game_over
`endif
);

  spy_state_e state, next_state;

  logic               p1_en_d, p2_en_d, p1_clear_d, p2_clear_d;
  logic               win_d, lose_d, game_over_d;
  logic [ROUND_W-1:0] round_d, score_d;
  logic               cd_load, cd_dec, cd_zero;
  logic               timeout, last_round, strike_out;

`ifdef SPY_STRIKES_EN
  logic [1:0] strikes_d;
  assign strike_out = (strikes == 2'(SPY_STRIKE_LIMIT));
`else
  assign strike_out = 1'b0;
`endif

  // A finish on the same cycle as the final tick wins, so the timer is
  // only decremented (and only times out) when no finish is present.
  assign cd_load    = (state == S_P1) && p1_finish;
  assign cd_dec     = (state == S_P2) && tick && !p2_finish;
  assign timeout    = (state == S_P2) && !p2_finish &&
                      (cd_zero || (tick && time_left == TIMER_W'(1)));
  assign last_round = (round == ROUND_W'(NUM_ROUNDS));

  spy_countdown #(.W(TIMER_W)) u_countdown (
    .clock    (clock),
    .reset    (reset),
    .load     (cd_load),
    .load_val (TIMER_W'(TIME_LIMIT)),
    .dec      (cd_dec),
    .count    (time_left),
    .zero     (cd_zero)
  );

  // State register plus registered copies of every output.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_IDLE;
      p1_en     <= 1'b0;
      p2_en     <= 1'b0;
      p1_clear  <= 1'b0;
      p2_clear  <= 1'b0;
      round     <= '0;
      score     <= '0;
      win       <= 1'b0;
      lose      <= 1'b0;
      game_over <= 1'b0;
`ifdef SPY_STRIKES_EN
      strikes   <= 2'b00;
`endif
    end else begin
      state     <= next_state;
      p1_en     <= p1_en_d;
      p2_en     <= p2_en_d;
      p1_clear  <= p1_clear_d;
      p2_clear  <= p2_clear_d;
      round     <= round_d;
      score     <= score_d;
      win       <= win_d;
      lose      <= lose_d;
      game_over <= game_over_d;
`ifdef SPY_STRIKES_EN
      strikes   <= strikes_d;
`endif
    end
  end

  // Next-state selection.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE,
      S_DONE:   if (start) next_state = S_P1;
      S_P1:     if (p1_finish) next_state = S_P2;
      S_P2: begin
        if (p2_finish)    next_state = S_CHECK;
        else if (timeout) next_state = S_RESULT;
      end
      S_CHECK:  next_state = S_RESULT;
      S_RESULT: next_state = (last_round || strike_out) ? S_DONE : S_P1;
      default:  next_state = S_IDLE;
    endcase
  end

  // Next output values; enables and game_over follow the state being entered.
  always_comb begin
    p1_en_d     = (next_state == S_P1);
    p2_en_d     = (next_state == S_P2);
    game_over_d = (next_state == S_DONE);
    p1_clear_d  = 1'b0;
    p2_clear_d  = 1'b0;
    win_d       = 1'b0;
    lose_d      = 1'b0;
    round_d     = round;
    score_d     = score;
`ifdef SPY_STRIKES_EN
    strikes_d   = strikes;
`endif
    case (state)
      S_IDLE,
      S_DONE: begin
        if (start) begin
          round_d    = ROUND_W'(1);
          score_d    = '0;
          p1_clear_d = 1'b1;
          p2_clear_d = 1'b1;
`ifdef SPY_STRIKES_EN
          strikes_d  = 2'b00;
`endif
        end
      end
      S_P1:     if (p1_finish) p2_clear_d = 1'b1;
      S_P2:     if (timeout) lose_d = 1'b1;
      S_CHECK: begin
        if (p2_match) begin
          win_d   = 1'b1;
          score_d = (score == '1) ? score : score + 1'b1;
        end else begin
          lose_d  = 1'b1;
        end
      end
      S_RESULT: begin
        if (!(last_round || strike_out)) begin
          round_d    = round + 1'b1;
          p1_clear_d = 1'b1;
          p2_clear_d = 1'b1;
        end
      end
      default: ;
    endcase
`ifdef SPY_STRIKES_EN
    if (lose_d && strikes_d != 2'b11) strikes_d = strikes_d + 1'b1;
`endif
  end

endmodule

// File: tb/tb_spy_round_ctrl.sv
// Directed bench for spy_round_ctrl (TIME_LIMIT=12, NUM_ROUNDS=5).
module tb_spy_round_ctrl;

  localparam int TL = 12;
  localparam int NR = 5;

  logic       clock = 1'b0;
  logic       reset, start, tick, p1_finish, p2_finish, p2_match;
  logic       p1_en, p2_en, p1_clear, p2_clear, win, lose, game_over;
  logic [5:0] time_left;
  logic [3:0] round, score;
`ifdef SPY_STRIKES_EN
  logic [1:0] strikes;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  spy_round_ctrl #(.TIME_LIMIT(TL), .NUM_ROUNDS(NR), .TIMER_W(6), .ROUND_W(4)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .tick      (tick),
    .p1_finish (p1_finish),
    .p2_finish (p2_finish),
    .p2_match  (p2_match),
    .p1_en     (p1_en),
    .p2_en     (p2_en),
    .p1_clear  (p1_clear),
    .p2_clear  (p2_clear),
    .time_left (time_left),
    .round     (round),
    .score     (score),
    .win       (win),
    .lose      (lose),
`ifdef SPY_STRIKES_EN
    .game_over (game_over),
    .strikes   (strikes)
`else
    .game_over (game_over)
`endif
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs are driven and outputs sampled 1 time unit later.
  task automatic clk();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_tick();
    tick = 1'b1; clk(); tick = 1'b0;
  endtask

  // Starting in P1_ENTRY: enter code, attempt with given match, walk to next round.
  task automatic play_round(input logic m);
    p1_finish = 1'b1; clk(); p1_finish = 1'b0;
    chk("p2_en_entry", p2_en, 1);
    p2_match = m; p2_finish = 1'b1; clk(); p2_finish = 1'b0;
    chk("check_p2_en", p2_en, 0);
    chk("check_no_pulse", win | lose, 0);
    clk();
    chk("result_win", win, m);
    chk("result_lose", lose, !m);
    clk();
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; tick = 1'b0;
    p1_finish = 1'b0; p2_finish = 1'b0; p2_match = 1'b0;
    clk(); clk();
    reset = 1'b0;
    chk("rst_p1_en", p1_en, 0);
    chk("rst_p2_en", p2_en, 0);
    chk("rst_round", round, 0);
    chk("rst_score", score, 0);
    chk("rst_time", time_left, 0);
    chk("rst_over", game_over, 0);
    chk("rst_winlose", win | lose, 0);

    // ignored inputs while idle
    p1_finish = 1'b1; tick = 1'b1; clk(); p1_finish = 1'b0; tick = 1'b0;
    chk("idle_ign_p1", p1_en, 0);

    // game start
    start = 1'b1; clk(); start = 1'b0;
    chk("start_p1_en", p1_en, 1);
    chk("start_p1_clr", p1_clear, 1);
    chk("start_p2_clr", p2_clear, 1);
    chk("start_round", round, 1);
    clk();
    chk("p1_clr_1cyc", p1_clear, 0);

    // round 1: win
    play_round(1'b1);
    chk("r2_round", round, 2);
    chk("r2_score", score, 1);
    chk("r2_p1_clr", p1_clear, 1);
    chk("r2_p2_clr", p2_clear, 1);

    // round 2: timeout
    p1_finish = 1'b1; clk(); p1_finish = 1'b0;
    chk("r2_load", time_left, TL);
    chk("r2_p2_clr_load", p2_clear, 1);
    for (int k = 1; k < TL; k++) begin
      pulse_tick();
      chk("r2_count", time_left, TL - k);
    end
    pulse_tick();
    chk("to_time", time_left, 0);
    chk("to_lose", lose, 1);
    chk("to_win", win, 0);
    chk("to_p2_en", p2_en, 0);
    chk("to_score", score, 1);
    clk();
    chk("r3_round", round, 3);
    chk("lose_1cyc", lose, 0);
    pulse_tick();
    chk("p1_tick_ign", time_left, 0);

    // round 3: finish together with the final tick
    p1_finish = 1'b1; clk(); p1_finish = 1'b0;
    for (int k = 1; k < TL; k++) pulse_tick();
    chk("r3_time1", time_left, 1);
    p2_match = 1'b1; p2_finish = 1'b1; tick = 1'b1; clk();
    p2_finish = 1'b0; tick = 1'b0;
    chk("sim_check_time", time_left, 1);
    chk("sim_check_p2en", p2_en, 0);
    clk();
    chk("sim_win", win, 1);
    chk("sim_lose", lose, 0);
    chk("sim_score", score, 2);
    chk("sim_time_hold", time_left, 1);
    clk();

    // rounds 4 and 5
    play_round(1'b0);
    chk("r5_round", round, 5);
    chk("r5_over", game_over, 0);
    play_round(1'b1);
    chk("done_over", game_over, 1);
    chk("done_round", round, 5);
    chk("done_score", score, 3);
    chk("done_p1_en", p1_en, 0);
`ifdef SPY_STRIKES_EN
    chk("done_strikes", strikes, 2);
`endif
    p2_finish = 1'b1; p1_finish = 1'b1; clk(); p2_finish = 1'b0; p1_finish = 1'b0;
    chk("done_hold", game_over, 1);
    chk("done_hold_sc", score, 3);

    // restart from DONE, then reset mid P2_ENTRY
    start = 1'b1; clk(); start = 1'b0;
    chk("re_round", round, 1);
    chk("re_score", score, 0);
    chk("re_over", game_over, 0);
    p1_finish = 1'b1; clk(); p1_finish = 1'b0;
    pulse_tick(); pulse_tick();
    chk("pre_rst_time", time_left, 10);
    reset = 1'b1; p2_match = 1'b1; clk();
    chk("mrst_p2_en", p2_en, 0);
    chk("mrst_time", time_left, 0);
    chk("mrst_round", round, 0);
    chk("mrst_pulse", win | lose, 0);
    reset = 1'b0; clk();
    chk("mrst_idle", p1_en | p2_en | game_over, 0);
    chk("mrst_pulse2", win | lose, 0);

    // three straight losses
    start = 1'b1; clk(); start = 1'b0;
    play_round(1'b0);
    play_round(1'b0);
    play_round(1'b0);
`ifdef SPY_STRIKES_EN
    chk("str_over", game_over, 1);
    chk("str_round", round, 3);
    chk("str_count", strikes, 3);
`else
    chk("nostr_over", game_over, 0);
    chk("nostr_round", round, 4);
    chk("nostr_p1_en", p1_en, 1);
`endif
    chk("str_score", score, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
